// File: rtl/axi_dma_arb_pkg.sv
// Shared types and helpers for the DMA channel arbiter.
// Package types are fixed at the default widths; the arbiter derives its own widths from its parameters.
package axi_dma_arb_pkg;

    localparam int unsigned DefNumChannels = 4;
    localparam int unsigned DefAddrWidth   = 64;
    localparam int unsigned DefLenWidth    = 32;

    typedef logic [$clog2(DefNumChannels)-1:0] chan_idx_t;

    typedef struct packed {
        logic [DefAddrWidth-1:0] src;
        logic [DefAddrWidth-1:0] dst;
        logic [DefLenWidth-1:0]  len;
    } dma_1d_req_t;

    // Next round-robin priority position after index idx among n requesters.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/fifo_v3.sv
// Small synchronous FIFO holding the channel index of each transfer outstanding at the backend.
// Push is ignored when full and pop is ignored when empty.
module fifo_v3 #(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned DATA_WIDTH = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  full_o,
    output logic                  empty_o
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PtrW-1:0]                  rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]                  wr_ptr_q, wr_ptr_d;
    logic [PtrW:0]                    cnt_q, cnt_d;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_q, mem_d;
    logic                             do_push, do_pop;

    assign full_o  = (cnt_q == (PtrW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign data_o  = mem_q[rd_ptr_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        mem_d    = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = wr_ptr_q + PtrW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + (PtrW+1)'(1);
        end else if (do_pop && !do_push) begin
            cnt_d = cnt_q - (PtrW+1)'(1);
        end
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage carries no control meaning, so it is left out of reset.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/axi_dma_channel_arbiter.sv
// Round-robin arbiter sharing one DMA backend between several 1D-transfer requesters,
// routing in-order backend completions back to the channel that issued each transfer.
module axi_dma_channel_arbiter
    import axi_dma_arb_pkg::*;
#(
    parameter int unsigned NumChannels = 4,
    parameter int unsigned AddrWidth   = 64,
    parameter int unsigned LenWidth    = 32,
    parameter int unsigned NumInFlight = 8
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [NumChannels-1:0]                req_valid_i,
    output logic [NumChannels-1:0]                req_ready_o,
    input  logic [NumChannels-1:0][AddrWidth-1:0] req_src_i,
    input  logic [NumChannels-1:0][AddrWidth-1:0] req_dst_i,
    input  logic [NumChannels-1:0][LenWidth-1:0]  req_len_i,
    output logic [NumChannels-1:0]                done_o,
    output logic [NumChannels-1:0]                busy_o,
    output logic                                  be_valid_o,
    input  logic                                  be_ready_i,
    output logic [AddrWidth-1:0]                  be_src_o,
    output logic [AddrWidth-1:0]                  be_dst_o,
    output logic [LenWidth-1:0]                   be_len_o,
    input  logic                                  be_done_i,
    output logic                                  err_o
);

    localparam int unsigned IdxW = (NumChannels > 1) ? $clog2(NumChannels) : 1;
    localparam int unsigned CntW = $clog2(NumInFlight + 1);

    typedef struct packed {
        logic [AddrWidth-1:0] src;
        logic [AddrWidth-1:0] dst;
        logic [LenWidth-1:0]  len;
    } req_t;

    logic [IdxW-1:0]                  rr_q, rr_d;
    logic [IdxW-1:0]                  winner, fifo_head;
    logic                             any_valid, grant, pop;
    logic                             fifo_full, fifo_empty;
    logic                             be_valid_q, be_valid_d;
    req_t                             be_req_q, be_req_d;
    logic [NumChannels-1:0]           done_q, done_d;
    logic                             err_q, err_d;
    logic [NumChannels-1:0][CntW-1:0] cnt_q, cnt_d;

    // First valid requester at or after the priority pointer, searching cyclically.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        winner    = '0;
        any_valid = 1'b0;
        for (int unsigned k = 0; k < NumChannels; k++) begin
            idx = (32'(rr_q) + k) % NumChannels;
            if (!any_valid && req_valid_i[idx[IdxW-1:0]]) begin
                any_valid = 1'b1;
                winner    = idx[IdxW-1:0];
            end
        end
    end

    // fifo_full is derived from registered occupancy only, so a completion cannot open a grant in the same cycle.
    assign grant = any_valid & (~be_valid_q | be_ready_i) & ~fifo_full & ~rst_i;
    assign pop   = be_done_i & ~fifo_empty;

    always_comb begin
        req_ready_o = '0;
        if (grant) begin
            req_ready_o[winner] = 1'b1;
        end
    end

    always_comb begin
        be_valid_d = be_valid_q;
        be_req_d   = be_req_q;
        rr_d       = rr_q;
        done_d     = '0;
        err_d      = err_q | (be_done_i & fifo_empty);
        cnt_d      = cnt_q;
        if (grant) begin
            be_valid_d   = 1'b1;
            be_req_d.src = req_src_i[winner];
            be_req_d.dst = req_dst_i[winner];
            be_req_d.len = req_len_i[winner];
            rr_d         = IdxW'(rr_next(32'(winner), NumChannels));
        end else if (be_ready_i) begin
            be_valid_d = 1'b0;
        end
        if (pop) begin
            done_d[fifo_head] = 1'b1;
        end
        for (int i = 0; i < NumChannels; i++) begin
            if (grant && winner == IdxW'(i) && !(pop && fifo_head == IdxW'(i))) begin
                cnt_d[i] = cnt_q[i] + CntW'(1);
            end else if (pop && fifo_head == IdxW'(i) && !(grant && winner == IdxW'(i))) begin
                cnt_d[i] = cnt_q[i] - CntW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_q       <= '0;
            be_valid_q <= 1'b0;
            be_req_q   <= '0;
            done_q     <= '0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            rr_q       <= rr_d;
            be_valid_q <= be_valid_d;
            be_req_q   <= be_req_d;
            done_q     <= done_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        for (int i = 0; i < NumChannels; i++) begin
            busy_o[i] = (cnt_q[i] != '0);
        end
    end

    assign be_valid_o = be_valid_q;
    assign be_src_o   = be_req_q.src;
    assign be_dst_o   = be_req_q.dst;
    assign be_len_o   = be_req_q.len;
    assign done_o     = done_q;
    assign err_o      = err_q;

    fifo_v3 #(
        .DEPTH      (NumInFlight),
        .DATA_WIDTH (IdxW)
    ) i_cpl_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (1'b0),
        .push_i  (grant),
        .data_i  (winner),
        .pop_i   (pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

endmodule

// File: tb/tb_axi_dma_channel_arbiter.sv
// Self-checking bench for axi_dma_channel_arbiter: directed scenarios plus randomized traffic
// compared against a queue-based reference model of the arbitration and completion routing.
module tb_axi_dma_channel_arbiter;

    localparam int N  = 4;
    localparam int AW = 64;
    localparam int LW = 32;
    localparam int D  = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N-1:0]         req_valid;
    logic [N-1:0]         req_ready;
    logic [N-1:0][AW-1:0] req_src;
    logic [N-1:0][AW-1:0] req_dst;
    logic [N-1:0][LW-1:0] req_len;
    logic [N-1:0]         done;
    logic [N-1:0]         busy;
    logic                 be_valid;
    logic                 be_ready;
    logic [AW-1:0]        be_src;
    logic [AW-1:0]        be_dst;
    logic [LW-1:0]        be_len;
    logic                 be_done;
    logic                 err;

    int tests = 0;
    int fails = 0;

    // Reference model state
    int            m_rr;
    int            m_q[$];
    bit            m_bv;
    logic [AW-1:0] m_src, m_dst;
    logic [LW-1:0] m_len;
    logic [N-1:0]  m_done;
    bit            m_err;
    bit            exp_grant;
    int            exp_winner;
    logic [N-1:0]  exp_ready;

    axi_dma_channel_arbiter #(
        .NumChannels (N),
        .AddrWidth   (AW),
        .LenWidth    (LW),
        .NumInFlight (D)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_src_i   (req_src),
        .req_dst_i   (req_dst),
        .req_len_i   (req_len),
        .done_o      (done),
        .busy_o      (busy),
        .be_valid_o  (be_valid),
        .be_ready_i  (be_ready),
        .be_src_o    (be_src),
        .be_dst_o    (be_dst),
        .be_len_o    (be_len),
        .be_done_i   (be_done),
        .err_o       (err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [N-1:0] model_busy();
        logic [N-1:0] b;
        b = '0;
        foreach (m_q[i]) b[m_q[i]] = 1'b1;
        return b;
    endfunction

    task automatic rand_payload();
        for (int c = 0; c < N; c++) begin
            req_src[c] = {$urandom, $urandom};
            req_dst[c] = {$urandom, $urandom};
            req_len[c] = $urandom;
        end
    endtask

    // Apply inputs after the falling edge and predict the combinational ready.
    task automatic drive(input logic [N-1:0] v, input bit rdy, input bit dn, input bit r);
        @(negedge clk);
        req_valid  = v;
        be_ready   = rdy;
        be_done    = dn;
        rst        = r;
        exp_grant  = 1'b0;
        exp_winner = 0;
        exp_ready  = '0;
        if (!r && (!m_bv || rdy) && m_q.size() < D) begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_rr + k) % N;
                if (v[c]) begin
                    exp_grant  = 1'b1;
                    exp_winner = c;
                    break;
                end
            end
        end
        if (exp_grant) exp_ready[exp_winner] = 1'b1;
        #1;
    endtask

    // Advance one clock and update the model with what that edge should have done.
    task automatic edge_update();
        @(posedge clk);
        if (rst) begin
            m_rr = 0;
            m_q.delete();
            m_bv = 1'b0;
            m_src = '0;
            m_dst = '0;
            m_len = '0;
            m_done = '0;
            m_err = 1'b0;
        end else begin
            m_done = '0;
            if (be_done) begin
                if (m_q.size() > 0) begin
                    m_done[m_q[0]] = 1'b1;
                    void'(m_q.pop_front());
                end else begin
                    m_err = 1'b1;
                end
            end
            if (exp_grant) begin
                m_bv  = 1'b1;
                m_src = req_src[exp_winner];
                m_dst = req_dst[exp_winner];
                m_len = req_len[exp_winner];
                m_q.push_back(exp_winner);
                m_rr = (exp_winner + 1) % N;
            end else if (be_ready) begin
                m_bv = 1'b0;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        drive('0, 1'b0, 1'b0, 1'b1);
        edge_update();
    endtask

    task automatic test_reset();
        rand_payload();
        drive('1, 1'b1, 1'b1, 1'b1);
        tests++;
        if (req_ready !== '0) begin fails++; $display("FAIL reset_ready got=%b exp=%b", req_ready, 4'b0); end
        edge_update();
        tests++;
        if (be_valid !== 1'b0 || be_src !== '0 || be_dst !== '0 || be_len !== '0) begin
            fails++; $display("FAIL reset_be got v=%b src=%h dst=%h len=%h exp all 0", be_valid, be_src, be_dst, be_len);
        end
        tests++;
        if (done !== '0 || busy !== '0 || err !== 1'b0) begin
            fails++; $display("FAIL reset_status got done=%b busy=%b err=%b exp 0", done, busy, err);
        end
    endtask

    task automatic test_single();
        do_reset();
        rand_payload();
        req_src[2] = 64'h1000;
        req_dst[2] = 64'h8000;
        req_len[2] = 32'd64;
        drive(4'b0100, 1'b1, 1'b0, 1'b0);
        tests++;
        if (req_ready !== 4'b0100) begin fails++; $display("FAIL single_ready got=%b exp=%b", req_ready, 4'b0100); end
        edge_update();
        tests++;
        if (be_valid !== 1'b1 || be_src !== 64'h1000 || be_dst !== 64'h8000 || be_len !== 32'd64) begin
            fails++; $display("FAIL single_payload got v=%b src=%h dst=%h len=%0d exp v=1 src=1000 dst=8000 len=64", be_valid, be_src, be_dst, be_len);
        end
        tests++;
        if (busy !== 4'b0100) begin fails++; $display("FAIL single_busy got=%b exp=%b", busy, 4'b0100); end
        drive(4'b0000, 1'b1, 1'b1, 1'b0);
        tests++;
        if (req_ready !== 4'b0000) begin fails++; $display("FAIL single_idle_ready got=%b exp=%b", req_ready, 4'b0); end
        edge_update();
        tests++;
        if (done !== 4'b0100 || busy !== 4'b0000 || be_valid !== 1'b0) begin
            fails++; $display("FAIL single_done got done=%b busy=%b v=%b exp done=0100 busy=0000 v=0", done, busy, be_valid);
        end
        drive(4'b0000, 1'b1, 1'b0, 1'b0);
        edge_update();
        tests++;
        if (done !== 4'b0000) begin fails++; $display("FAIL single_done_pulse got=%b exp=%b", done, 4'b0); end
    endtask

    task automatic test_fairness();
        int cnt[N];
        int grants;
        int cyc;
        int gidx;
        grants = 0;
        cyc = 0;
        foreach (cnt[i]) cnt[i] = 0;
        do_reset();
        while (grants < 100 && cyc < 300) begin
            rand_payload();
            drive('1, 1'b1, m_q.size() > 0, 1'b0);
            tests++;
            if (req_ready !== exp_ready) begin fails++; $display("FAIL fair_ready got=%b exp=%b", req_ready, exp_ready); end
            if (req_ready != '0) begin
                gidx = 0;
                for (int c = 0; c < N; c++) if (req_ready[c]) gidx = c;
                tests++;
                if (gidx != grants % N) begin fails++; $display("FAIL fair_order got=%0d exp=%0d", gidx, grants % N); end
                cnt[gidx]++;
                grants++;
            end
            edge_update();
            tests++;
            if (be_valid !== m_bv || be_src !== m_src || done !== m_done) begin
                fails++; $display("FAIL fair_out got v=%b src=%h done=%b exp v=%b src=%h done=%b", be_valid, be_src, done, m_bv, m_src, m_done);
            end
            cyc++;
        end
        tests++;
        if (grants != 100) begin fails++; $display("FAIL fair_grants got=%0d exp=100", grants); end
        for (int c = 0; c < N; c++) begin
            tests++;
            if (cnt[c] != 25) begin fails++; $display("FAIL fair_share ch%0d got=%0d exp=25", c, cnt[c]); end
        end
    endtask

    task automatic test_backpressure();
        logic [AW-1:0] s_src, s_dst;
        logic [LW-1:0] s_len;
        do_reset();
        rand_payload();
        drive(4'b0010, 1'b0, 1'b0, 1'b0);
        tests++;
        if (req_ready !== 4'b0010) begin fails++; $display("FAIL bp_first_ready got=%b exp=%b", req_ready, 4'b0010); end
        s_src = req_src[1];
        s_dst = req_dst[1];
        s_len = req_len[1];
        edge_update();
        for (int k = 0; k < 10; k++) begin
            rand_payload();
            drive('1, 1'b0, 1'b0, 1'b0);
            tests++;
            if (req_ready !== '0) begin fails++; $display("FAIL bp_stall_ready cyc%0d got=%b exp=%b", k, req_ready, 4'b0); end
            edge_update();
            tests++;
            if (be_valid !== 1'b1 || be_src !== s_src || be_dst !== s_dst || be_len !== s_len) begin
                fails++; $display("FAIL bp_hold cyc%0d got v=%b src=%h dst=%h len=%h exp v=1 src=%h dst=%h len=%h", k, be_valid, be_src, be_dst, be_len, s_src, s_dst, s_len);
            end
        end
        drive('1, 1'b1, 1'b0, 1'b0);
        tests++;
        if (req_ready !== 4'b0100) begin fails++; $display("FAIL bp_release_ready got=%b exp=%b", req_ready, 4'b0100); end
        s_src = req_src[2];
        edge_update();
        tests++;
        if (be_valid !== 1'b1 || be_src !== s_src) begin
            fails++; $display("FAIL bp_release_payload got v=%b src=%h exp v=1 src=%h", be_valid, be_src, s_src);
        end
    endtask

    task automatic test_fifo_full();
        int iss[$];
        int exp_h;
        do_reset();
        for (int k = 0; k < D; k++) begin
            rand_payload();
            drive('1, 1'b1, 1'b0, 1'b0);
            tests++;
            if (req_ready !== exp_ready || req_ready === '0) begin fails++; $display("FAIL full_fill_ready k%0d got=%b exp=%b", k, req_ready, exp_ready); end
            iss.push_back(exp_winner);
            edge_update();
        end
        for (int k = 0; k < 3; k++) begin
            drive('1, 1'b1, 1'b0, 1'b0);
            tests++;
            if (req_ready !== '0) begin fails++; $display("FAIL full_blocked k%0d got=%b exp=%b", k, req_ready, 4'b0); end
            edge_update();
        end
        drive('1, 1'b1, 1'b1, 1'b0);
        tests++;
        if (req_ready !== '0) begin fails++; $display("FAIL full_done_same_cycle got=%b exp=%b", req_ready, 4'b0); end
        edge_update();
        exp_h = iss.pop_front();
        tests++;
        if (done !== 4'(1 << exp_h)) begin fails++; $display("FAIL full_first_done got=%b exp=%b", done, 4'(1 << exp_h)); end
        rand_payload();
        drive('1, 1'b1, 1'b0, 1'b0);
        tests++;
        if ($countones(req_ready) != 1 || req_ready !== exp_ready) begin fails++; $display("FAIL full_reopen got=%b exp=%b", req_ready, exp_ready); end
        iss.push_back(exp_winner);
        edge_update();
        drive('1, 1'b1, 1'b0, 1'b0);
        tests++;
        if (req_ready !== '0) begin fails++; $display("FAIL full_again got=%b exp=%b", req_ready, 4'b0); end
        edge_update();
        while (iss.size() > 0) begin
            drive('0, 1'b1, 1'b1, 1'b0);
            edge_update();
            exp_h = iss.pop_front();
            tests++;
            if (done !== 4'(1 << exp_h)) begin fails++; $display("FAIL full_drain_order got=%b exp=%b", done, 4'(1 << exp_h)); end
        end
        tests++;
        if (busy !== '0 || err !== 1'b0) begin fails++; $display("FAIL full_drained got busy=%b err=%b exp busy=0000 err=0", busy, err); end
    endtask

    task automatic test_protocol_error();
        do_reset();
        drive('0, 1'b1, 1'b1, 1'b0);
        edge_update();
        tests++;
        if (err !== 1'b1 || done !== '0) begin fails++; $display("FAIL perr_set got err=%b done=%b exp err=1 done=0000", err, done); end
        for (int k = 0; k < 5; k++) begin
            drive('0, 1'b1, 1'b0, 1'b0);
            edge_update();
            tests++;
            if (err !== 1'b1) begin fails++; $display("FAIL perr_sticky cyc%0d got=%b exp=1", k, err); end
        end
        drive('0, 1'b1, 1'b0, 1'b1);
        edge_update();
        tests++;
        if (err !== 1'b0) begin fails++; $display("FAIL perr_clear got=%b exp=0", err); end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            rand_payload();
            drive('1, 1'b1, 1'b0, 1'b0);
            edge_update();
        end
        tests++;
        if (busy !== 4'b0111 || be_valid !== 1'b1) begin fails++; $display("FAIL mid_loaded got busy=%b v=%b exp busy=0111 v=1", busy, be_valid); end
        drive('1, 1'b1, 1'b0, 1'b1);
        tests++;
        if (req_ready !== '0) begin fails++; $display("FAIL mid_rst_ready got=%b exp=%b", req_ready, 4'b0); end
        edge_update();
        tests++;
        if (be_valid !== 1'b0 || be_src !== '0 || be_dst !== '0 || be_len !== '0 || done !== '0 || busy !== '0 || err !== 1'b0) begin
            fails++; $display("FAIL mid_rst_outputs got v=%b src=%h len=%h done=%b busy=%b err=%b exp all 0", be_valid, be_src, be_len, done, busy, err);
        end
        drive('0, 1'b1, 1'b1, 1'b0);
        edge_update();
        tests++;
        if (err !== 1'b1 || done !== '0) begin fails++; $display("FAIL mid_late_done got err=%b done=%b exp err=1 done=0000", err, done); end
    endtask

    task automatic test_random();
        logic [N-1:0] v;
        bit rdy, dn, r;
        do_reset();
        for (int k = 0; k < 800; k++) begin
            rand_payload();
            v   = N'($urandom);
            rdy = ($urandom_range(0, 3) != 0);
            dn  = (m_q.size() > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 99) == 0);
            r   = ($urandom_range(0, 199) == 0);
            drive(v, rdy, dn, r);
            tests++;
            if (req_ready !== exp_ready) begin fails++; $display("FAIL rnd_ready cyc%0d got=%b exp=%b", k, req_ready, exp_ready); end
            edge_update();
            tests++;
            if (be_valid !== m_bv || be_src !== m_src || be_dst !== m_dst || be_len !== m_len) begin
                fails++; $display("FAIL rnd_be cyc%0d got v=%b src=%h dst=%h len=%h exp v=%b src=%h dst=%h len=%h", k, be_valid, be_src, be_dst, be_len, m_bv, m_src, m_dst, m_len);
            end
            tests++;
            if (done !== m_done || busy !== model_busy() || err !== m_err) begin
                fails++; $display("FAIL rnd_status cyc%0d got done=%b busy=%b err=%b exp done=%b busy=%b err=%b", k, done, busy, err, m_done, model_busy(), m_err);
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        be_ready  = 1'b0;
        be_done   = 1'b0;
        req_src   = '0;
        req_dst   = '0;
        req_len   = '0;
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_fifo_full();
        test_protocol_error();
        test_reset_midflight();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
